// File: rtl/multicycle_cu.sv
// Multicycle control unit for a small ARMv8 subset (R-type, ADDI/SUBI, LDUR/STUR, CBZ, B).
// Moore-style FSM with a memory-wait watchdog and a retired-instruction counter.
module multicycle_cu #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] Opcode,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        IorD,
    output logic        Reg2Loc,
    output logic        ALUSrcA,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  state,
    output logic        error,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StExecI   = 4'd3,
        StAluWb   = 4'd4,
        StMemAddr = 4'd5,
        StMemRd   = 4'd6,
        StLdWb    = 4'd7,
        StMemWr   = 4'd8,
        StCbz     = 4'd9,
        StBranch  = 4'd10,
        StError   = 4'd15
    } state_e;

    localparam logic [10:0] OpAdd  = 11'b10001011000;
    localparam logic [10:0] OpSub  = 11'b11001011000;
    localparam logic [10:0] OpAnd  = 11'b10001010000;
    localparam logic [10:0] OpOrr  = 11'b10101010000;
    localparam logic [10:0] OpLdur = 11'b11111000010;
    localparam logic [10:0] OpStur = 11'b11111000000;
    localparam logic [3:0]  TimeoutCnt = 4'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;
    logic        timeout;

    assign timeout = (wait_q == TimeoutCnt);

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StError;
                end
            end
            StDecode: begin
                casez (Opcode)
                    OpAdd, OpSub, OpAnd, OpOrr:       state_d = StExecR;
                    11'b1001000100?, 11'b1101000100?: state_d = StExecI;
                    OpLdur, OpStur:                   state_d = StMemAddr;
                    11'b10110100???:                  state_d = StCbz;
                    11'b000101?????:                  state_d = StBranch;
                    default:                          state_d = StError;
                endcase
            end
            StExecR, StExecI: state_d = StAluWb;
            StMemAddr: begin
                if (Opcode == OpLdur) begin
                    state_d = StMemRd;
                end else if (Opcode == OpStur) begin
                    state_d = StMemWr;
                end else begin
                    state_d = StError;
                end
            end
            StMemRd: begin
                if (mem_ready) begin
                    state_d = StLdWb;
                end else if (timeout) begin
                    state_d = StError;
                end
            end
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d = StError;
                end
            end
            StAluWb, StLdWb, StCbz, StBranch: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    // Remaining in a memory state implies mem_ready was low; any other move re-arms the watchdog.
    always_comb begin
        wait_d = '0;
        if ((state_q == StFetch || state_q == StMemRd || state_q == StMemWr) &&
            state_d == state_q) begin
            wait_d = wait_q + 4'd1;
        end
        instret_d = instret_q + 32'(retire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    // While reset is held the outputs show the idle FETCH decode, whatever state_q holds.
    state_e out_st;
    logic   out_rdy;

    assign out_st  = rst_n ? state_q : StFetch;
    assign out_rdy = rst_n & mem_ready;

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        Reg2Loc  = 1'b0;
        ALUSrcA  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 3'b000;
        PCSource = 2'b00;
        error    = 1'b0;
        case (out_st)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = out_rdy;
                IRWrite = out_rdy;
            end
            StDecode: ALUSrcB = 2'b11;
            StExecR: begin
                ALUSrcA = 1'b1;
                case (Opcode)
                    OpSub:   ALUOp = 3'b001;
                    OpAnd:   ALUOp = 3'b010;
                    OpOrr:   ALUOp = 3'b011;
                    default: ALUOp = 3'b000;
                endcase
            end
            StExecI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = Opcode[9] ? 3'b001 : 3'b000;
            end
            StAluWb: RegWrite = 1'b1;
            StMemAddr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                Reg2Loc = 1'b1;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StLdWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Reg2Loc  = 1'b1;
            end
            StCbz: begin
                Reg2Loc  = 1'b1;
                ALUSrcA  = 1'b1;
                ALUOp    = 3'b100;
                PCSource = 2'b01;
                PCWrite  = Zero;
            end
            StBranch: begin
                PCWrite  = 1'b1;
                PCSource = 2'b01;
            end
            StError: error = 1'b1;
            default: ;
        endcase
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of consecutive wait cycles tolerated on mem_ready before the ERROR state is entered.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port Opcode  input  11  instruction bits [31:21], taken from the instruction register.
REQ-005 SHALL have port Zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory handshake; the current read or write completes in a cycle where it is 1.
REQ-007 SHALL have the following strobe ports, each output 1: PCWrite, IRWrite, IorD (0=PC address, 1=ALUOut address), Reg2Loc, ALUSrcA (0=PC, 1=reg A), MemRead, MemWrite, MemtoReg, RegWrite.
REQ-008 SHALL have port ALUSrcB  output  2  ALU B-operand select: 00=reg B, 01=constant 4, 10=sign-extended D/I immediate, 11=branch offset <<2.
REQ-009 SHALL have port ALUOp  output  3  ALU operation: 000=add, 001=sub, 010=and, 011=or, 100=pass B.
REQ-010 SHALL have port PCSource  output  2  next-PC select: 00=ALU result, 01=ALUOut; 10 and 11 are reserved.
REQ-011 SHALL have port state  output  4  current FSM state encoding.
REQ-012 SHALL have port error  output  1  sticky fault flag.
REQ-013 SHALL have port instret  output  32  count of retired instructions.

Function
REQ-014 SHALL use the following state encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, MEM_ADDR=5, MEM_RD=6, LD_WB=7, MEM_WR=8, CBZ=9, BRANCH=10, ERROR=15; codes 11-14 SHALL transition to ERROR.
REQ-015 SHALL drive every output that is not explicitly listed for a state to 0, so that only the listed outputs are active in that state.
REQ-016 In FETCH: SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; SHALL assert IRWrite=1 and PCWrite=1 only in the cycle where mem_ready=1, and then go to DECODE; otherwise SHALL stay in FETCH.
REQ-017 In DECODE: SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut); the next state SHALL be chosen from Opcode by the first match below.
REQ-018 ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 SHALL go to EXEC_R.
REQ-019 ADDI 1001000100x and SUBI 1101000100x SHALL go to EXEC_I.
REQ-020 LDUR 11111000010 and STUR 11111000000 SHALL go to MEM_ADDR.
REQ-021 CBZ 10110100xxx SHALL go to CBZ.
REQ-022 B 000101xxxxx SHALL go to BRANCH.
REQ-023 Any other opcode SHALL go to ERROR.
REQ-024 In EXEC_R: SHALL drive ALUSrcA=1, ALUSrcB=00, Reg2Loc=0, ALUOp = ADD 000 / SUB 001 / AND 010 / ORR 011, then go to ALU_WB.
REQ-025 In EXEC_I: SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp = ADDI 000 / SUBI 001, then go to ALU_WB.
REQ-026 In ALU_WB: SHALL drive RegWrite=1 and MemtoReg=0, then go to FETCH.
REQ-027 In MEM_ADDR: SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=000, Reg2Loc=1, then go to MEM_RD for LDUR or MEM_WR for STUR.
REQ-028 In MEM_RD: SHALL drive MemRead=1 and IorD=1; on mem_ready=1 SHALL go to LD_WB.
REQ-029 In LD_WB: SHALL drive RegWrite=1 and MemtoReg=1, then go to FETCH.
REQ-030 In MEM_WR: SHALL drive MemWrite=1, IorD=1, Reg2Loc=1; on mem_ready=1 SHALL go to FETCH.
REQ-031 In CBZ: SHALL drive Reg2Loc=1, ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCSource=01, and PCWrite=Zero, then go to FETCH.
REQ-032 In BRANCH: SHALL drive PCWrite=1 and PCSource=01, then go to FETCH.
REQ-033 With mem_ready tied to 1, latency from FETCH entry back to FETCH SHALL be: R/I-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3.
REQ-034 A 4-bit wait counter SHALL clear on entry to FETCH, MEM_RD and MEM_WR, and SHALL increment in each cycle of those states where mem_ready=0.
REQ-035 When the wait counter equals MEM_TIMEOUT with mem_ready=0, the next state SHALL be ERROR.
REQ-036 mem_ready=1 in the same cycle as the timeout SHALL take priority over the timeout, and the access SHALL complete normally.
REQ-037 In ERROR: SHALL drive error=1 with all strobes 0, and SHALL remain in ERROR until reset.
REQ-038 instret SHALL increment by 1 on every transition into FETCH from ALU_WB, LD_WB, MEM_WR, CBZ or BRANCH, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-039 Opcode SHALL only be sampled in DECODE, EXEC_R, EXEC_I and MEM_ADDR; changes to Opcode in other states SHALL have no effect.

Reset
REQ-040 When rst_n=0 at a clock edge, regardless of the current state (including mid-access or ERROR), the block SHALL set state=FETCH, wait counter=0, instret=0, error=0.
REQ-041 While in reset and in the first cycle after reset, outputs SHALL equal the FETCH decode with mem_ready=0: MemRead=1, ALUSrcB=01, and all other strobes 0.

Verification
REQ-042 SHALL cover: ADD opcode, mem_ready=1 -> states 0,1,2,4,0; RegWrite=1 only in state 4; instret=1.
REQ-043 SHALL cover: LDUR, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then LD_WB with MemtoReg=1, total 8 cycles.
REQ-044 SHALL cover: CBZ with Zero=1 -> PCWrite=1, PCSource=01 in state 9; CBZ with Zero=0 -> PCWrite=0; B -> PCWrite=1 in state 10.
REQ-045 SHALL cover: opcode 11111111111 in DECODE -> state 15 with error=1, which persists 20 cycles and clears on rst_n=0.
REQ-046 SHALL cover: mem_ready held 0 in FETCH -> ERROR after 16 cycles; in a second run, mem_ready=1 on the 16th cycle -> DECODE instead.
REQ-047 SHALL cover: instret preloaded via force to 0xFFFFFFFF, then one B retires -> instret=0; and rst_n=0 asserted in MEM_WR -> FETCH next cycle with MemWrite=0.
